// File: rtl/uart_gen2_pkg.sv
// Shared types and constants for the gen2 UART core.
// UART_PARITY_EN adds the PARITY states to both FSM encodings.
package uart_gen2_pkg;

    localparam int SB_TICK  = 16;
    localparam int DBIT_MAX = 9;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_e;

    // Received character plus its error flags; data is sized for the widest legal DBIT.
    typedef struct packed {
        logic                parity_err;
        logic                frame_err;
        logic [DBIT_MAX-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy counter.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO still accepts a write when the same cycle pops the head.
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && !empty;
    assign rdata = mem[rd_ptr];

    // Storage array write port.
    // NOTE: the array is deliberately not reset; the count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_core_gen2.sv
// Full-duplex 16x-oversampling UART with TX/RX FIFOs, error flags and overrun.
// Define UART_PARITY_EN to build parity generation/checking.
module uart_core_gen2
    import uart_gen2_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int FIFO_AW = 4,
    parameter int SB_TICK = uart_gen2_pkg::SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     dvsr,
    input  logic            enable,
    input  logic            stop2,
    input  logic [1:0]      parity_mode,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] transmit_data,
    output logic            tx_full,
    output logic            tx,
    input  logic            rx,
    input  logic            rd_uart,
    output logic            rx_empty,
    output logic [DBIT-1:0] receive_data,
    output logic [1:0]      rx_status,
    output logic            rx_overrun,
    input  logic            clr_err
);

    localparam logic [4:0] BIT_END   = 5'(SB_TICK - 1);
    localparam logic [4:0] START_MID = 5'(SB_TICK/2 - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DBIT - 1);

    logic [15:0] baud_cnt;
    logic        tick;

    // Baud counter: runs 0..dvsr while enabled, held at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            baud_cnt <= '0;
        else if (!enable || baud_cnt >= dvsr)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 16'd1;
    end

    assign tick = enable && (baud_cnt == dvsr);

`ifdef UART_PARITY_EN
    logic par_en;
    logic par_odd;
    assign par_en  = (parity_mode == EVEN) || (parity_mode == ODD);
    assign par_odd = (parity_mode == ODD);
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    // ---------------- transmitter ----------------
    tx_state_e       tx_state;
    logic [4:0]      tx_s;
    logic [3:0]      tx_n;
    logic [DBIT-1:0] tx_shreg;
    logic [DBIT-1:0] tx_fifo_data;
    logic            tx_fifo_empty;
    logic            tx_pop;
    logic            tx_stop_done;
`ifdef UART_PARITY_EN
    logic            tx_par;
`endif

    assign tx_stop_done = tick && (tx_state == TX_STOP) &&
                          (tx_s == 5'(stop2 ? 2*SB_TICK - 1 : SB_TICK - 1));
    // Loading straight out of STOP keeps back-to-back characters gapless.
    assign tx_pop = !tx_fifo_empty && ((tx_state == TX_IDLE && enable) || tx_stop_done);

    // TX FSM with registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_shreg <= '0;
            tx       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_shreg <= tx_fifo_data;
            tx       <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= (^tx_fifo_data) ^ par_odd;
`endif
        end else if (tx_stop_done) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
        end else if (tick) begin
            case (tx_state)
                TX_START: begin
                    if (tx_s == BIT_END) begin
                        tx_s     <= '0;
                        tx_state <= TX_DATA;
                        tx       <= tx_shreg[0];
                    end else
                        tx_s <= tx_s + 5'd1;
                end
                TX_DATA: begin
                    if (tx_s == BIT_END) begin
                        tx_s <= '0;
                        if (tx_n == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            if (par_en) begin
                                tx_state <= TX_PARITY;
                                tx       <= tx_par;
                            end else begin
                                tx_state <= TX_STOP;
                                tx       <= 1'b1;
                            end
`else
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            tx_n     <= tx_n + 4'd1;
                            tx_shreg <= tx_shreg >> 1;
                            tx       <= tx_shreg[1];
                        end
                    end else
                        tx_s <= tx_s + 5'd1;
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_s == BIT_END) begin
                        tx_s     <= '0;
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                    end else
                        tx_s <= tx_s + 5'd1;
                end
`endif
                TX_STOP: tx_s <= tx_s + 5'd1;
                default: ;
            endcase
        end
    end

    uart_fifo #(.WIDTH(DBIT), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_uart),
        .rd    (tx_pop),
        .wdata (transmit_data),
        .rdata (tx_fifo_data),
        .full  (tx_full),
        .empty (tx_fifo_empty)
    );

    // ---------------- receiver ----------------
    logic            rx_meta;
    logic            rx_sync;
    rx_state_e       rx_state;
    logic [4:0]      rx_s;
    logic [3:0]      rx_n;
    logic [DBIT-1:0] rx_shreg;
    logic            rx_push;
    logic            rx_fifo_full;
    logic [DBIT+1:0] rx_rdata;
    logic [DBIT+1:0] rx_wdata;
    rx_entry_t       rx_push_entry;
    logic            unused_entry;
`ifdef UART_PARITY_EN
    logic            rx_perr;
`endif

    // Two-flop synchroniser, idling at the line's mark level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_push = tick && (rx_state == RX_STOP) && (rx_s == BIT_END);

    // RX FSM: mid-bit sampling after centring on the start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_shreg <= '0;
`ifdef UART_PARITY_EN
            rx_perr  <= 1'b0;
`endif
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (enable && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_s     <= '0;
                        rx_n     <= '0;
`ifdef UART_PARITY_EN
                        rx_perr  <= 1'b0;
`endif
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_s == START_MID) begin
                            rx_s     <= '0;
                            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                        end else
                            rx_s <= rx_s + 5'd1;
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_s == BIT_END) begin
                            rx_s     <= '0;
                            rx_shreg <= {rx_sync, rx_shreg[DBIT-1:1]};
                            if (rx_n == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                rx_state <= par_en ? RX_PARITY : RX_STOP;
`else
                                rx_state <= RX_STOP;
`endif
                            end else
                                rx_n <= rx_n + 4'd1;
                        end else
                            rx_s <= rx_s + 5'd1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (tick) begin
                        if (rx_s == BIT_END) begin
                            rx_s     <= '0;
                            rx_perr  <= rx_sync ^ (^rx_shreg) ^ par_odd;
                            rx_state <= RX_STOP;
                        end else
                            rx_s <= rx_s + 5'd1;
                    end
                end
`endif
                RX_STOP: begin
                    if (tick) begin
                        if (rx_s == BIT_END) begin
                            rx_s     <= '0;
                            rx_state <= RX_IDLE;
                        end else
                            rx_s <= rx_s + 5'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Assemble the entry written at the stop-bit sample.
    // NOTE: defaulting the whole struct first keeps this block free of latches.
    always_comb begin
        rx_push_entry                = '0;
`ifdef UART_PARITY_EN
        rx_push_entry.parity_err     = rx_perr;
`endif
        rx_push_entry.frame_err      = !rx_sync;
        rx_push_entry.data[DBIT-1:0] = rx_shreg;
    end

    assign rx_wdata     = {rx_push_entry.parity_err, rx_push_entry.frame_err,
                           rx_push_entry.data[DBIT-1:0]};
    assign unused_entry = ^rx_push_entry.data;

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rx_overrun <= 1'b0;
        else if (rx_push && rx_fifo_full)
            rx_overrun <= 1'b1;
        else if (clr_err)
            rx_overrun <= 1'b0;
    end

    uart_fifo #(.WIDTH(DBIT + 2), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_push),
        .rd    (rd_uart),
        .wdata (rx_wdata),
        .rdata (rx_rdata),
        .full  (rx_fifo_full),
        .empty (rx_empty)
    );

    // The unreset storage never leaks out: outputs read zero while empty.
    assign receive_data = rx_empty ? '0 : rx_rdata[DBIT-1:0];
    assign rx_status    = rx_empty ? 2'b00 : rx_rdata[DBIT+1:DBIT];

endmodule

// File: tb/tb_uart_core_gen2.sv
// Scoreboard bench for uart_core_gen2: loopback and bit-banged RX traffic.
`timescale 1ns/1ps
module tb_uart_core_gen2;

    localparam int DBIT    = 8;
    localparam int FIFO_AW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     dvsr;
    logic            enable;
    logic            stop2;
    logic [1:0]      parity_mode;
    logic            wr_uart;
    logic [DBIT-1:0] transmit_data;
    logic            tx_full;
    logic            tx;
    logic            rx;
    logic            rd_uart;
    logic            rx_empty;
    logic [DBIT-1:0] receive_data;
    logic [1:0]      rx_status;
    logic            rx_overrun;
    logic            clr_err;

    logic loop_en;
    logic rx_drv;
    logic mon_en;

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core_gen2 #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .dvsr          (dvsr),
        .enable        (enable),
        .stop2         (stop2),
        .parity_mode   (parity_mode),
        .wr_uart       (wr_uart),
        .transmit_data (transmit_data),
        .tx_full       (tx_full),
        .tx            (tx),
        .rx            (rx),
        .rd_uart       (rd_uart),
        .rx_empty      (rx_empty),
        .receive_data  (receive_data),
        .rx_status     (rx_status),
        .rx_overrun    (rx_overrun),
        .clr_err       (clr_err)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] status;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int bit_clks();
        return 16 * (int'(dvsr) + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_char(input logic [7:0] d, input logic [1:0] st);
        exp_t e;
        e.data   = d;
        e.status = st;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an RX entry.
    initial begin
        exp_t e;
        rd_uart = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_uart)
                rd_uart = 1'b0;
            else if (mon_en && !reset && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got data 0x%0h status %0b, expected no entry",
                             receive_data, rx_status);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", receive_data, e.data);
                    check("rx_status", rx_status, e.status);
                end
                rd_uart = 1'b1;
            end
        end
    end

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        wr_uart       = 1'b1;
        transmit_data = d;
        @(negedge clk);
        wr_uart       = 1'b0;
    endtask

    task automatic wait_not_full();
        int k = 0;
        while (tx_full && k < 10000) begin
            @(posedge clk);
            k++;
        end
        if (tx_full) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_full_stuck: got tx_full 1 after %0d clocks, expected 0", k);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d entries outstanding after %0d clocks, expected 0",
                     name, exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    task automatic wait_tx_low(input string name);
        int k = 0;
        while (tx !== 1'b0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check(name, tx, 1'b0);
    endtask

    // Bit-banged character on rx; a bad stop bit is held 3/4 of a bit then released.
    task automatic rx_send(input logic [7:0] d, input bit use_par, input logic par_bit,
                           input bit good_stop);
        rx_drv = 1'b0;
        repeat (bit_clks()) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (bit_clks()) @(posedge clk);
        end
        if (use_par) begin
            rx_drv = par_bit;
            repeat (bit_clks()) @(posedge clk);
        end
        if (good_stop) begin
            rx_drv = 1'b1;
            repeat (bit_clks()) @(posedge clk);
        end else begin
            rx_drv = 1'b0;
            repeat (bit_clks() * 3 / 4) @(posedge clk);
            rx_drv = 1'b1;
            repeat (bit_clks() * 2) @(posedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        int         k;

        reset = 1'b1; enable = 1'b0; dvsr = 16'd3; stop2 = 1'b0; parity_mode = 2'b00;
        wr_uart = 1'b0; transmit_data = '0; rx_drv = 1'b1; loop_en = 1'b1;
        clr_err = 1'b0; mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_tx_full", tx_full, 1'b0);
        check("reset_rx_empty", rx_empty, 1'b1);
        check("reset_receive_data", receive_data, 8'h00);
        check("reset_rx_status", rx_status, 2'b00);
        check("reset_rx_overrun", rx_overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Fill TX FIFO with the baud generator off; the fifth write must be dropped.
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            tx_write(d);
            expect_char(d, 2'b00);
        end
        check("tx_full_at_depth", tx_full, 1'b1);
        tx_write(8'hEE);
        check("tx_full_after_extra", tx_full, 1'b1);
        check("tx_idle_while_disabled", tx, 1'b1);
        mon_en = 1'b1;
        enable = 1'b1;
        wait_drain("burst_loopback", 4 * 160 * 4 + 800);
        repeat (bit_clks() * 2) @(posedge clk);

        // 8N1 loopback of 0xA5 with the two-clock write-to-start latency.
        @(negedge clk);
        wr_uart       = 1'b1;
        transmit_data = 8'hA5;
        expect_char(8'hA5, 2'b00);
        @(posedge clk);
        #1;
        check("tx_one_clk_after_write", tx, 1'b1);
        @(negedge clk);
        wr_uart = 1'b0;
        @(posedge clk);
        #1;
        check("tx_start_two_clk_after_write", tx, 1'b0);
        wait_drain("loopback_a5", 800);
        repeat (bit_clks() * 2) @(posedge clk);

        // Randomised loopback at a faster baud, one and two stop bits.
        dvsr = 16'd1;
        for (int b = 0; b < 2; b++) begin
            stop2 = b[0];
            for (int i = 0; i < 6; i++) begin
                wait_not_full();
                d = 8'($urandom);
                tx_write(d);
                expect_char(d, 2'b00);
            end
            wait_drain("random_loopback", 6 * 192 * 2 + 800);
            repeat (bit_clks() * 3) @(posedge clk);
        end
        stop2 = 1'b0;
        dvsr  = 16'd3;
        repeat (bit_clks() * 2) @(posedge clk);

`ifdef UART_PARITY_EN
        // Even parity: 0x03 has an even number of ones, so the parity bit is 0.
        parity_mode = 2'b01;
        tx_write(8'h03);
        expect_char(8'h03, 2'b00);
        wait_tx_low("even_start_bit");
        repeat (bit_clks() * 9 + bit_clks() / 2) @(posedge clk);
        #1;
        check("even_parity_bit", tx, 1'b0);
        wait_drain("even_loopback", 1000);
        repeat (bit_clks() * 2) @(posedge clk);
        loop_en = 1'b0;
        expect_char(8'h03, 2'b10);
        rx_send(8'h03, 1'b1, 1'b1, 1'b1);
        wait_drain("even_parity_error", 400);
        loop_en = 1'b1;
        parity_mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            tx_write(d);
            expect_char(d, 2'b00);
        end
        wait_drain("odd_loopback", 3 * 176 * 4 + 800);
        repeat (bit_clks() * 2) @(posedge clk);
        parity_mode = 2'b00;
`endif

        // Framing error: 0x55 with a low stop bit is still stored, flagged 01.
        loop_en = 1'b0;
        expect_char(8'h55, 2'b01);
        rx_send(8'h55, 1'b0, 1'b0, 1'b0);
        wait_drain("framing_error", 400);

        // Glitch: a one-tick low pulse must not produce an entry.
        mon_en = 1'b0;
        rx_drv = 1'b0;
        repeat (int'(dvsr) + 1) @(posedge clk);
        rx_drv = 1'b1;
        repeat (bit_clks() * 12) @(posedge clk);
        #1;
        check("glitch_no_push", rx_empty, 1'b1);
        mon_en = 1'b1;
        expect_char(8'h3C, 2'b00);
        rx_send(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_drain("after_glitch", 400);

        // Overrun: five characters into a four-entry FIFO with no reads.
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (i < 4)
                expect_char(d, 2'b00);
            rx_send(d, 1'b0, 1'b0, 1'b1);
        end
        repeat (10) @(posedge clk);
        #1;
        check("overrun_set", rx_overrun, 1'b1);
        mon_en = 1'b1;
        wait_drain("overrun_stored", 100);
        repeat (4) @(posedge clk);
        #1;
        check("overrun_empty_after_reads", rx_empty, 1'b1);
        check("overrun_sticky", rx_overrun, 1'b1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("overrun_cleared", rx_overrun, 1'b0);

        // Reset in the middle of a frame with data buffered on both sides.
        mon_en  = 1'b0;
        loop_en = 1'b1;
        tx_write(8'h5A);
        k = 0;
        while (rx_empty && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("rx_buffered_before_reset", rx_empty, 1'b0);
        repeat (bit_clks() * 2) @(posedge clk);
        tx_write(8'h00);
        for (int i = 0; i < 4; i++)
            tx_write(8'($urandom));
        check("tx_full_before_reset", tx_full, 1'b1);
        wait_tx_low("reset_frame_start");
        repeat (bit_clks() * 3) @(posedge clk);
        #1;
        check("tx_low_in_data", tx, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midframe_tx", tx, 1'b1);
        check("midframe_rx_empty", rx_empty, 1'b1);
        check("midframe_tx_full", tx_full, 1'b0);
        check("midframe_receive_data", receive_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        enable = 1'b1;
        d = 8'($urandom);
        tx_write(d);
        expect_char(d, 2'b00);
        wait_drain("after_reset_frame", 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_core_gen2.md
# uart_core_gen2

Parametrised full-duplex UART core: a 16x-oversampling baud generator, a transmitter and a receiver with configurable data width, stop bits and parity, each side buffered by a FIFO. It is the next-generation UART engine behind the existing `uart_interface` signal set. It adds per-character error status, overrun detection and FIFO depth selection, none of which the current 8N1 core has. It sits between a register/bus front end (the `wr_uart`/`rd_uart` strobes) and the serial pins.

## Interface
Parameters:
- `DBIT`, 8: data bits per character, legal 5..9.
- `FIFO_AW`, 4: FIFO address width; each FIFO holds 2**FIFO_AW entries.
- `SB_TICK`, 16: oversample ticks per bit, fixed at 16 in this generation.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous reset, active-high.
- `dvsr` in 16: baud divisor. Tick period is dvsr+1 clocks.
- `enable` in 1: baud generator enable.
- `stop2` in 1: 1 selects two stop bits, 0 selects one.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `wr_uart` in 1: pushes `transmit_data` into the TX FIFO.
- `transmit_data` in DBIT: character to send.
- `tx_full` out 1: TX FIFO full.
- `tx` out 1: serial output, idle high.
- `rx` in 1: serial input, asynchronous.
- `rd_uart` in 1: pops the RX FIFO head.
- `rx_empty` out 1: RX FIFO empty.
- `receive_data` out DBIT: RX FIFO head, first-word-fall-through.
- `rx_status` out 2: head-entry flags, {parity_err, frame_err}.
- `rx_overrun` out 1: sticky overrun flag.
- `clr_err` in 1: clears `rx_overrun`.

## Operation
- **Reset values:** `tx`=1, `tx_full`=0, `rx_empty`=1, `receive_data`=0, `rx_status`=0, `rx_overrun`=0. Both FSMs start in IDLE. The baud counter resets to 0.
- **Baud generator:**
  - Counter counts 0..dvsr, wraps to 0, and pulses `tick` for one clock when it equals dvsr.
  - `enable`=0 holds the counter at 0 and produces no ticks. Both FSMs freeze in their current state.
  - `dvsr` is sampled live. A change takes effect at the next wrap.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE, a non-empty FIFO pops one entry into the shift register and enters START on the same clock.
  - START drives 0 and DATA drives the LSB first. PARITY drives the XOR of the data bits, inverted when odd parity is selected. STOP drives 1.
  - Each state lasts 16 ticks. STOP lasts 32 ticks when `stop2`=1.
  - Back-to-back characters leave no idle gap.
- **RX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - `rx` passes through a 2-flop synchroniser whose flops reset to 1.
  - IDLE leaves on a synchronised 0.
  - START samples at tick 7. If the line is 1, the FSM returns to IDLE (glitch rejection) and nothing is pushed.
  - DATA and PARITY sample at every 16th tick. STOP samples once, at its 16th tick; a second stop bit is not checked.
  - `frame_err` is set when the stop sample is 0. `parity_err` is set when the received parity bit mismatches the computed parity.
  - Push {flags, data} into the RX FIFO at the end of STOP, including errored characters.
  - If the RX FIFO is full at push time, the character is dropped and `rx_overrun` is set. `clr_err` clears it; if a set and a clear occur on the same cycle, the set wins.
- **FIFOs:**
  - A write when full is ignored. A read when empty is ignored.
  - Read and write in the same cycle: when full, both occur and the count is unchanged. When empty, only the write occurs.
  - Pointers wrap modulo 2**FIFO_AW. Full and empty are derived from a count of width FIFO_AW+1.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronously). The partial RX character is discarded and both FIFOs are emptied.

## Timing
- Bit time is 16·(dvsr+1) clocks.
- An 8N1 frame takes 160·(dvsr+1) clocks. 8E2 takes 192·(dvsr+1).
- `wr_uart` into an idle TX FIFO: `tx` falls 2 clocks later (FIFO write, then pop and START register).
- RX: `rx_empty` deasserts 1 clock after the STOP sample tick. The synchroniser adds 2 clocks of input delay.
- `tx_full` and `rx_empty` update the clock after the causing strobe. `receive_data` and `rx_status` are valid whenever `rx_empty`=0.

## Configuration
- `UART_PARITY_EN` defined: parity generation and checking are built, and `parity_mode` is honoured.
- Not defined: PARITY states and logic are omitted, `parity_mode` is ignored, and `rx_status[1]` is tied to 0.

## Structure
- Package `uart_gen2_pkg` holds:
  - `parity_e` (NONE, EVEN, ODD);
  - the `tx_state_e` and `rx_state_e` enums;
  - the `rx_entry_t` struct {parity_err, frame_err, data};
  - the `SB_TICK` constant.
- Sub-module `uart_fifo` (parameters WIDTH and AW) is instantiated twice: TX with WIDTH=DBIT, RX with WIDTH=DBIT+2.

## Test plan
- **Loopback 8N1:** dvsr=3, write 0xA5 → `rx_empty` falls about 640 clocks later, `receive_data`=0xA5, `rx_status`=00.
- **Even parity:** `UART_PARITY_EN`, parity_mode=01, send 0x03 → parity bit 0 on `tx`. Force the parity bit to 1 on `rx` → `rx_status`=10.
- **Framing error:** drive `rx` with 0x55 and stop bit 0 → entry pushed with `rx_status`=01.
- **Overrun:** FIFO_AW=2, receive 5 characters with no reads → 4 stored, `rx_overrun`=1, and `clr_err` clears it.
- **Glitch:** a 1-tick low pulse on `rx` → no push, FSM back in IDLE.
- **Reset mid-frame:** assert `reset` during DATA → `tx`=1 in the same cycle, `rx_empty`=1, `tx_full`=0. The next frame after reset is correct.
